// File: rtl/control_fsm_pkg.sv
// rtl/control_fsm_pkg.sv - shared state, opcode, func and ALU encodings for the multicycle control path
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b0101;
    localparam logic [3:0] OP_SW    = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // True for every opcode/func pair the datapath can execute.
    function automatic logic legal_instr(input logic [3:0] opcode, input logic [2:0] func);
        case (opcode)
            OP_RTYPE:                            return (func <= FN_XOR);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle CPU control FSM (fetch/decode/exec/mem/writeback)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr[15:0]       instruction register: [15:12] opcode, [2:0] func
//   mem_ready         memory access completes in a cycle where this is 1
//   zero              ALU zero flag for BEQ
//   ir_write, pc_write, mem_read, mem_write, reg_write   datapath enables
//   alu_op[1:0], b_negate                                ALU control
//   alu_src_b[1:0], pc_src[1:0], mem_to_reg, reg_dst, alu_src_a   mux selects
//   state[2:0]        current state code
//   illegal           one-cycle pulse in DECODE on an undefined opcode/func
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        b_negate,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        alu_src_a,
    output logic [2:0]  state,
    output logic        illegal
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode;
    logic [2:0] func;
    logic       unused_instr_bits;

    assign opcode            = instr[15:12];
    assign func              = instr[2:0];
    assign unused_instr_bits = ^instr[11:3];
    assign state             = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Everything is decoded only while out of reset, so all enables and
    // selects read 0 for the whole time rst_n is low, not just after an edge.
    always_comb begin
        state_d    = ST_FETCH;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_AND;
        b_negate   = 1'b0;
        alu_src_b  = SRC_B_REG;
        pc_src     = PC_SRC_ALU;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    // PC+1 is computed every fetch cycle but committed only
                    // together with the instruction word.
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_ONE;
                    alu_op    = ALU_ADD;
                    pc_src    = PC_SRC_ALU;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    // Branch target is precomputed into ALUOut here.
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                    if (opcode == OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end else if (!legal_instr(opcode, func)) begin
                        illegal = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_REG;
                            state_d   = ST_WB;
                            case (func)
                                FN_AND: alu_op = ALU_AND;
                                FN_OR:  alu_op = ALU_OR;
                                FN_ADD: alu_op = ALU_ADD;
                                FN_SUB: begin
                                    alu_op   = ALU_ADD;
                                    b_negate = 1'b1;
                                end
                                FN_XOR: alu_op = ALU_XOR;
                                default: state_d = ST_FETCH;
                            endcase
                        end
                        OP_ADDI, OP_LW, OP_SW: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_ADD;
                            state_d   = (opcode == OP_ADDI) ? ST_WB : ST_MEM;
                        end
                        OP_BEQ: begin
                            // A - B; the branch commits in this same cycle.
                            alu_src_a = 1'b1;
                            alu_src_b = SRC_B_REG;
                            alu_op    = ALU_ADD;
                            b_negate  = 1'b1;
                            pc_src    = PC_SRC_ALUOUT;
                            pc_write  = zero;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (opcode == OP_LW) begin
                        mem_read = 1'b1;
                        state_d  = mem_ready ? ST_WB : ST_MEM;
                    end else if (opcode == OP_SW) begin
                        mem_write = 1'b1;
                        state_d   = mem_ready ? ST_FETCH : ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_RTYPE);
                    mem_to_reg = (opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm with a per-instruction reference model
module tb_control_fsm;

    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       b_negate;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [15:0] instr;
        logic        mem_ready;
        logic        zero;
        outs_t       exp;
    } cyc_t;

    typedef struct {
        outs_t       exp;
        logic [15:0] instr;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write;
    logic [1:0]  alu_op;
    logic        b_negate;
    logic [1:0]  alu_src_b, pc_src;
    logic        mem_to_reg, reg_dst, alu_src_a;
    logic [2:0]  state;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    cyc_t plan[$];
    sb_t  sb_q[$];

    control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .b_negate   (b_negate),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic outs_t dut_outs();
        return {state, ir_write, pc_write, mem_read, mem_write, reg_write, alu_op, b_negate,
                alu_src_b, pc_src, mem_to_reg, reg_dst, alu_src_a, illegal};
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: lists every cycle of one instruction with the inputs to
    // drive and the outputs the control path must present in that cycle.
    // fw/mw = cycles memory stays not-ready during fetch / data access.
    task automatic plan_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
        logic [3:0] opc = ins[15:12];
        logic [2:0] fn  = ins[2:0];
        logic is_r    = (opc == 4'h0) && (fn <= 3'd4);
        logic is_addi = (opc == 4'h4);
        logic is_lw   = (opc == 4'h5);
        logic is_sw   = (opc == 4'h6);
        logic is_beq  = (opc == 4'h7);
        logic is_j    = (opc == 4'h8);
        logic is_bad  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_j);
        logic [1:0] r_op [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        cyc_t c;
        outs_t o;

        // fetch: instruction bus carries garbage, it must be ignored here
        for (int i = 0; i <= fw; i++) begin
            o = '0;
            o.state = 3'd0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
            c.instr = 16'($urandom); c.zero = 1'($urandom);
            c.mem_ready = (i == fw);
            if (i == fw) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
            c.exp = o;
            plan.push_back(c);
        end

        c.instr = ins; c.mem_ready = 1'($urandom); c.zero = 1'($urandom);
        o = '0;
        o.state = 3'd1; o.alu_src_b = 2'b10; o.alu_op = 2'b10;
        if (is_j) begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
        if (is_bad) o.illegal = 1'b1;
        c.exp = o;
        plan.push_back(c);
        if (is_j || is_bad) return;

        c.mem_ready = 1'($urandom); c.zero = 1'($urandom);
        o = '0;
        o.state = 3'd2; o.alu_src_a = 1'b1;
        if (is_r) begin
            o.alu_op = r_op[fn];
            o.b_negate = (fn == 3'd3);
        end else if (is_beq) begin
            c.zero = z;
            o.alu_op = 2'b10; o.b_negate = 1'b1; o.pc_src = 2'b01; o.pc_write = z;
        end else begin
            o.alu_src_b = 2'b10; o.alu_op = 2'b10;
        end
        c.exp = o;
        plan.push_back(c);
        if (is_beq) return;

        if (is_lw || is_sw) begin
            for (int i = 0; i <= mw; i++) begin
                o = '0;
                o.state = 3'd3; o.mem_read = is_lw; o.mem_write = is_sw;
                c.mem_ready = (i == mw); c.zero = 1'($urandom);
                c.exp = o;
                plan.push_back(c);
            end
        end
        if (is_sw) return;

        o = '0;
        o.state = 3'd4; o.reg_write = 1'b1; o.reg_dst = is_r; o.mem_to_reg = is_lw;
        c.mem_ready = 1'($urandom); c.zero = 1'($urandom);
        c.exp = o;
        plan.push_back(c);
    endtask

    // Driver: issues one planned cycle per clock, pushing its expected
    // outputs into the scoreboard as the stimulus is applied.
    task automatic run_plan();
        cyc_t c;
        sb_t  e;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(posedge clk);
            #1;
            e.exp = c.exp; e.instr = c.instr;
            sb_q.push_back(e);
            instr = c.instr; mem_ready = c.mem_ready; zero = c.zero;
        end
    endtask

    task automatic do_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
        plan_instr(ins, fw, mw, z);
        run_plan();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: every cycle is an output cycle for this block.
    always @(negedge clk) begin
        sb_t e;
        string nm;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            nm = $sformatf("cycle instr=%h", e.instr);
            check(nm, dut_outs(), e.exp);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        outs_t o;
        logic [3:0] opc_tab [6] = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        logic [15:0] ins;

        rst_n = 1'b0; instr = 16'h0000; mem_ready = 1'b1; zero = 1'b0;
        #3;
        check("reset outputs", dut_outs(), '0);
        @(posedge clk);
        #3;
        check("reset held over edge", dut_outs(), '0);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
        check("fetch after release", dut_outs(), o);

        do_instr(16'h0003, 0, 0, 1'b0);       // SUB
        do_instr(16'h5000, 0, 2, 1'b0);       // LW, two memory waits
        do_instr(16'h7000, 0, 0, 1'b1);       // BEQ taken
        do_instr(16'h7000, 0, 0, 1'b0);       // BEQ not taken
        do_instr(16'hF000, 0, 0, 1'b0);       // undefined opcode
        do_instr(16'h8000, 0, 0, 1'b0);       // J
        do_instr(16'h0005, 1, 0, 1'b0);       // undefined func
        do_instr(16'h6abc, 2, 1, 1'b0);       // SW with fetch waits

        for (int k = 0; k < 40; k++) begin
            int sel = $urandom_range(0, 7);
            ins = 16'($urandom);
            if (sel < 6) ins[15:12] = opc_tab[sel];
            do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end
        wait_empty();

        // SW abandoned by reset while waiting in MEM
        @(posedge clk); #1 instr = 16'($urandom); mem_ready = 1'b1;
        @(posedge clk); #1 instr = 16'h6000;
        @(posedge clk); #1;
        @(posedge clk); #1 mem_ready = 1'b0;
        #2;
        o = '0; o.state = 3'd3; o.mem_write = 1'b1;
        check("sw waiting in mem", dut_outs(), o);
        #1 rst_n = 1'b0;
        #1;
        check("async reset mid mem", dut_outs(), '0);
        @(posedge clk); #1;
        check("reset holds through edge", dut_outs(), '0);
        @(posedge clk); #3 rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
        check("fetch after mid reset", dut_outs(), o);

        do_instr(16'h4123, 0, 0, 1'b0);       // ADDI right after reset
        do_instr(16'h0004, 1, 0, 1'b0);       // XOR
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
